// File: rtl/instruction_fetch.sv
// PC register and IF/ID output stage: drives the async-read ROM address from pc_q,
// captures the returned word, and presents {pc, instruction} to decode over valid/ready.
package riscv_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INSTRUCTION_BYTES = 4;
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;
endpackage

module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_enable,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [XLEN-1:0]              rom_address,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_instruction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic                         redirect_misaligned,
  output logic [XLEN-1:0]              fetched_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_e;

  stage_e                       state, state_nxt;
  logic [XLEN-1:0]              pc_q, pc_nxt;
  logic [XLEN-1:0]              opc_nxt;
  logic [INSTRUCTION_WIDTH-1:0] oinst_nxt;
  logic                         mis_nxt;
  logic                         handshake;

  assign out_valid   = (state == FULL);
  assign rom_address = pc_q;
  assign handshake   = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    opc_nxt   = out_pc;
    oinst_nxt = out_instruction;
    mis_nxt   = 1'b0;
    if (redirect_valid) begin
      // Flush the stage; the held out_pc/out_instruction are don't-care while empty.
      state_nxt = EMPTY;
      pc_nxt    = {redirect_pc[XLEN-1:2], 2'b00};
      mis_nxt   = |redirect_pc[1:0];
    end else if (fetch_enable && (!out_valid || out_ready)) begin
      state_nxt = FULL;
      opc_nxt   = pc_q;
      oinst_nxt = rom_instruction;
      pc_nxt    = pc_q + XLEN'(INSTRUCTION_BYTES);
    end else if (handshake) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= EMPTY;
      pc_q                <= RESET_PC;
      out_pc              <= '0;
      out_instruction     <= NOP_INSTRUCTION;
      redirect_misaligned <= 1'b0;
      fetched_count       <= '0;
    end else begin
      state               <= state_nxt;
      pc_q                <= pc_nxt;
      out_pc              <= opc_nxt;
      out_instruction     <= oinst_nxt;
      redirect_misaligned <= mis_nxt;
      // A handshake on a redirect edge still counts: decode took the entry.
      if (handshake) fetched_count <= fetched_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed vector bench for instruction_fetch: table of per-edge stimulus and expected
// outputs, plus hand-written async-reset sequences.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        redirect_misaligned;
  logic [31:0] fetched_count;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_address(rom_address), .rom_instruction(rom_instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instruction(out_instruction), .redirect_misaligned(redirect_misaligned),
    .fetched_count(fetched_count)
  );

  always #5 clk = ~clk;

  // Bench ROM: word 0x40 (byte 0x100) holds 0xAA, everything else is address-tagged.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a[31:2] == 30'h40) return 32'h0000_00AA;
    return 32'hC000_0000 ^ a;
  endfunction

  assign rom_instruction = rom_word(rom_address);

  typedef struct {
    logic        fe, rv, rdy;
    logic [31:0] rpc;
    logic        e_valid, e_mis;
    logic [31:0] e_pc, e_inst, e_cnt, e_rom;
  } vec_t;

  function automatic vec_t mk(input logic fe, rv, rdy, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, einst,
                              input logic emis, input logic [31:0] ecnt, erom);
    vec_t v;
    v.fe = fe; v.rv = rv; v.rdy = rdy; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_inst = einst; v.e_mis = emis;
    v.e_cnt = ecnt; v.e_rom = erom;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic ev, input logic [31:0] epc, einst,
                         input logic emis, input logic [31:0] ecnt, erom);
    chk("out_valid", idx, {31'b0, out_valid}, {31'b0, ev});
    chk("out_pc", idx, out_pc, epc);
    chk("out_instruction", idx, out_instruction, einst);
    chk("redirect_misaligned", idx, {31'b0, redirect_misaligned}, {31'b0, emis});
    chk("fetched_count", idx, fetched_count, ecnt);
    chk("rom_address", idx, rom_address, erom);
  endtask

  vec_t vecs[15];

  initial begin
    // fe rv rdy rpc | valid pc inst mis cnt rom
    vecs[0]  = mk(1,0,1,0,           1, 32'h100, 32'hAA,            0, 0, 32'h104);
    vecs[1]  = mk(1,0,1,0,           1, 32'h104, rom_word(32'h104), 0, 1, 32'h108);
    vecs[2]  = mk(1,0,0,0,           1, 32'h104, rom_word(32'h104), 0, 1, 32'h108);
    vecs[3]  = mk(1,0,0,0,           1, 32'h104, rom_word(32'h104), 0, 1, 32'h108);
    vecs[4]  = mk(1,0,0,0,           1, 32'h104, rom_word(32'h104), 0, 1, 32'h108);
    vecs[5]  = mk(1,0,1,0,           1, 32'h108, rom_word(32'h108), 0, 2, 32'h10C);
    vecs[6]  = mk(1,1,1,32'h20,      0, 32'h108, rom_word(32'h108), 0, 3, 32'h20);
    vecs[7]  = mk(1,0,1,0,           1, 32'h20,  rom_word(32'h20),  0, 3, 32'h24);
    vecs[8]  = mk(1,1,0,32'h23,      0, 32'h20,  rom_word(32'h20),  1, 3, 32'h20);
    vecs[9]  = mk(1,0,1,0,           1, 32'h20,  rom_word(32'h20),  0, 3, 32'h24);
    vecs[10] = mk(0,0,1,0,           0, 32'h20,  rom_word(32'h20),  0, 4, 32'h24);
    vecs[11] = mk(0,0,1,0,           0, 32'h20,  rom_word(32'h20),  0, 4, 32'h24);
    vecs[12] = mk(1,1,1,32'hFFFF_FFFC, 0, 32'h20, rom_word(32'h20), 0, 4, 32'hFFFF_FFFC);
    vecs[13] = mk(1,0,1,0,           1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 0, 4, 32'h0);
    vecs[14] = mk(1,0,1,0,           1, 32'h0,   rom_word(32'h0),   0, 5, 32'h4);

    // Reset state while held in reset.
    #12;
    chk_all(100, 0, 32'h0, 32'h13, 0, 0, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      fetch_enable   = vecs[i].fe;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      @(posedge clk); #1;
      chk_all(i, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_mis,
              vecs[i].e_cnt, vecs[i].e_rom);
    end

    // Async reset mid-stream: values must return before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(200, 0, 32'h0, 32'h13, 0, 0, RST_PC);
    @(posedge clk); #1;
    chk_all(201, 0, 32'h0, 32'h13, 0, 0, RST_PC);

    // Release with a stalled decode: first entry appears one edge later and holds.
    @(negedge clk);
    rst_n = 1'b1; fetch_enable = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_all(300, 1, 32'h100, 32'hAA, 0, 0, 32'h104);
    @(posedge clk); #1;
    chk_all(301, 1, 32'h100, 32'hAA, 0, 0, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, want finish before 50000");
    $fatal(1, "timeout");
  end
endmodule
